// File: rtl/fractal_axi_regbank.sv
// AXI4-Lite register bank: RW control words, RO status words, per-word write pulses, SLVERR on bad accesses.
// Define FRACTAL_AXI_IRQ_EN to append the sticky IRQ_STAT (W1C) and IRQ_EN words and drive the irq line.
module fractal_axi_regbank #(
   parameter int          S_AXI_DATA_WIDTH = 32,
   parameter int          S_AXI_ADDR_WIDTH = 6,
   parameter int          NUM_CTRL         = 8,
   parameter int          NUM_STAT         = 4,
   parameter int          NUM_IRQ          = 4,
   parameter logic [31:0] CTRL_RESET       = 32'h0
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [32*NUM_CTRL-1:0]        ctrl_regs,
   output logic [NUM_CTRL-1:0]           ctrl_wr_pulse,
   input  logic [32*NUM_STAT-1:0]        stat_regs,
   input  logic [NUM_IRQ-1:0]            irq_src,
   output logic                          irq
);
   localparam int         IDX_W       = S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic [31:0]           w_data_q, w_data_d;
   logic [3:0]            w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d, awready_q, awready_d, wready_q, wready_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [32*NUM_CTRL-1:0] ctrl_q, ctrl_d;
   logic [NUM_CTRL-1:0]   pulse_q, pulse_d;
   logic [31:0]           wr_idx, rd_idx;

   logic                  ar_pend_q, ar_pend_d, arready_q, arready_d, rvalid_q, rvalid_d;
   logic [IDX_W-1:0]      ar_idx_q, ar_idx_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

`ifdef FRACTAL_AXI_IRQ_EN
   localparam int IRQ_STAT_IDX = NUM_CTRL + NUM_STAT;
   localparam int IRQ_EN_IDX   = NUM_CTRL + NUM_STAT + 1;
   logic [NUM_IRQ-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, irq_clr;
   logic               irq_q, irq_d;
`endif

   // Address and data are held independently; the commit fires once both are present and no B is pending.
   always_comb begin
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      ctrl_d    = ctrl_q;
      pulse_d   = '0;
      wr_idx    = 32'(aw_idx_q);
`ifdef FRACTAL_AXI_IRQ_EN
      irq_en_d  = irq_en_q;
      irq_clr   = '0;
`endif
      if (S_AXI_AWVALID && awready_q) begin
         aw_held_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:2];
      end
      if (S_AXI_WVALID && wready_q) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end
      if (aw_held_q && w_held_q && !bvalid_q) begin
         bvalid_d = 1'b1;
         bresp_d  = RESP_SLVERR;
         for (int i = 0; i < NUM_CTRL; i++) begin
            if (wr_idx == 32'(i)) begin
               ctrl_d[32*i +: 32] = apply_strb(ctrl_q[32*i +: 32], w_data_q, w_strb_q);
               pulse_d[i]         = 1'b1;
               bresp_d            = RESP_OKAY;
            end
         end
`ifdef FRACTAL_AXI_IRQ_EN
         if (wr_idx == 32'(IRQ_STAT_IDX)) begin
            irq_clr = NUM_IRQ'(apply_strb(32'h0, w_data_q, w_strb_q));
            bresp_d = RESP_OKAY;
         end
         if (wr_idx == 32'(IRQ_EN_IDX)) begin
            irq_en_d = NUM_IRQ'(apply_strb(32'(irq_en_q), w_data_q, w_strb_q));
            bresp_d  = RESP_OKAY;
         end
`endif
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
      awready_d = !aw_held_d && !bvalid_d;
      wready_d  = !w_held_d && !bvalid_d;
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         ctrl_q    <= {NUM_CTRL{CTRL_RESET}};
         pulse_q   <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         ctrl_q    <= ctrl_d;
         pulse_q   <= pulse_d;
      end
   end

   // Reads decode from the registered word values, so a same-edge commit is not yet visible.
   always_comb begin
      ar_pend_d = ar_pend_q;
      ar_idx_d  = ar_idx_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_idx    = 32'(ar_idx_q);
      if (S_AXI_ARVALID && arready_q) begin
         ar_pend_d = 1'b1;
         ar_idx_d  = S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:2];
      end
      if (ar_pend_q) begin
         ar_pend_d = 1'b0;
         rvalid_d  = 1'b1;
         rdata_d   = '0;
         rresp_d   = RESP_SLVERR;
         for (int i = 0; i < NUM_CTRL; i++) begin
            if (rd_idx == 32'(i)) begin
               rdata_d = ctrl_q[32*i +: 32];
               rresp_d = RESP_OKAY;
            end
         end
         for (int i = 0; i < NUM_STAT; i++) begin
            if (rd_idx == 32'(NUM_CTRL + i)) begin
               rdata_d = stat_regs[32*i +: 32];
               rresp_d = RESP_OKAY;
            end
         end
`ifdef FRACTAL_AXI_IRQ_EN
         if (rd_idx == 32'(IRQ_STAT_IDX)) begin
            rdata_d = 32'(irq_stat_q);
            rresp_d = RESP_OKAY;
         end
         if (rd_idx == 32'(IRQ_EN_IDX)) begin
            rdata_d = 32'(irq_en_q);
            rresp_d = RESP_OKAY;
         end
`endif
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
      arready_d = !rvalid_d && !ar_pend_d;
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         ar_pend_q <= 1'b0;
         ar_idx_q  <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         ar_pend_q <= ar_pend_d;
         ar_idx_q  <= ar_idx_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

`ifdef FRACTAL_AXI_IRQ_EN
   // A source that is high on the clearing edge keeps its bit set.
   always_comb begin
      irq_stat_d = (irq_stat_q & ~irq_clr) | irq_src;
      irq_d      = |(irq_stat_q & irq_en_q);
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         irq_stat_q <= '0;
         irq_en_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_stat_q <= irq_stat_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   logic unused_irq_src;
   assign unused_irq_src = ^irq_src;
   assign irq            = 1'b0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign ctrl_regs     = ctrl_q;
   assign ctrl_wr_pulse = pulse_q;
endmodule
